// File: rtl/vec_alu_pkg.sv
// Shared types and lane arithmetic for the vec_alu_arbiter slice.
// Define VEC_ALU_ARBITER_SAT_EN to saturate lane results instead of wrapping.
package vec_alu_pkg;

  localparam int LANE_W = 8;
  localparam int LANES  = 4;
  localparam int VEC_W  = LANE_W * LANES;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // One signed 8-bit lane; the 9-bit intermediate exposes overflow for clamping.
  function automatic logic [LANE_W-1:0] lane_calc(input logic op,
                                                  input logic [LANE_W-1:0] a,
                                                  input logic [LANE_W-1:0] b);
    logic signed [LANE_W:0] sum_s;
    if (op == OP_SUB) begin
      sum_s = {a[LANE_W-1], a} - {b[LANE_W-1], b};
    end else begin
      sum_s = {a[LANE_W-1], a} + {b[LANE_W-1], b};
    end
`ifdef VEC_ALU_ARBITER_SAT_EN
    if (sum_s > 9'sd127) begin
      return 8'h7f;
    end else if (sum_s < -9'sd128) begin
      return 8'h80;
    end else begin
      return sum_s[LANE_W-1:0];
    end
`else
    return sum_s[LANE_W-1:0];
`endif
  endfunction

  function automatic logic [VEC_W-1:0] vec_calc(input logic op,
                                               input logic [VEC_W-1:0] a,
                                               input logic [VEC_W-1:0] b);
    logic [VEC_W-1:0] y_s;
    y_s = {VEC_W{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      y_s[k*LANE_W +: LANE_W] = lane_calc(op, a[k*LANE_W +: LANE_W], b[k*LANE_W +: LANE_W]);
    end
    return y_s;
  endfunction

endpackage

// File: rtl/vec_alu_i8v4.sv
// LAT-stage 4-lane i8 add/sub datapath: stage 1 latches the operands on load,
// later stages carry the result so it appears LAT cycles after the load cycle.
module vec_alu_i8v4
  import vec_alu_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             op,
  input  logic [VEC_W-1:0] a,
  input  logic [VEC_W-1:0] b,
  output logic [VEC_W-1:0] y
);

  logic             op_r;
  logic [VEC_W-1:0] a_r;
  logic [VEC_W-1:0] b_r;
  logic [VEC_W-1:0] res_s;

  // Operand capture stage, loaded only on the accept cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      op_r <= 1'b0;
      a_r  <= {VEC_W{1'b0}};
      b_r  <= {VEC_W{1'b0}};
    end else if (load) begin
      op_r <= op;
      a_r  <= a;
      b_r  <= b;
    end else begin
      op_r <= op_r;
      a_r  <= a_r;
      b_r  <= b_r;
    end
  end

  assign res_s = vec_calc(op_r, a_r, b_r);

  generate
    if (LAT == 1) begin : g_lat1
      assign y = res_s;
    end else begin : g_pipe
      logic [VEC_W-1:0] pipe_r [LAT-1];

      // Result delay line for the remaining LAT-1 stages
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int i = 0; i < LAT - 1; i++) begin
            pipe_r[i] <= {VEC_W{1'b0}};
          end
        end else begin
          pipe_r[0] <= res_s;
          for (int i = 1; i < LAT - 1; i++) begin
            pipe_r[i] <= pipe_r[i-1];
          end
        end
      end

      assign y = pipe_r[LAT-2];
    end
  endgenerate

endmodule

// File: rtl/vec_alu_arbiter.sv
// Round-robin arbiter sharing one vec_alu_i8v4 between two requesters.
// Build option: VEC_ALU_ARBITER_SAT_EN selects saturating lane arithmetic.
module vec_alu_arbiter
  import vec_alu_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_op,
  input  logic [VEC_W-1:0] req0_a,
  input  logic [VEC_W-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_op,
  input  logic [VEC_W-1:0] req1_a,
  input  logic [VEC_W-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [VEC_W-1:0] rsp_y
);

  localparam logic [3:0] CNT_LAST = 4'(LAT - 1);

  state_e           state_r;
  state_e           state_next_s;
  logic             gid_r;
  logic             prio_r;
  logic [3:0]       cnt_r;
  logic             rsp0_valid_r;
  logic             rsp1_valid_r;
  logic [VEC_W-1:0] rsp_y_r;
  logic             gnt_valid_s;
  logic             gnt_id_s;
  logic             rsp_take_s;
  logic             sel_op_s;
  logic [VEC_W-1:0] sel_a_s;
  logic [VEC_W-1:0] sel_b_s;
  logic [VEC_W-1:0] alu_y_s;

  // Grant decode: a lone requester wins, a tie goes to the priority pointer
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_id_s    = 1'b0;
    if (!reset && (state_r == IDLE) && (req0_valid || req1_valid)) begin
      gnt_valid_s = 1'b1;
      if (req0_valid && req1_valid) begin
        gnt_id_s = prio_r;
      end else begin
        gnt_id_s = req1_valid;
      end
    end else begin
      gnt_valid_s = 1'b0;
      gnt_id_s    = 1'b0;
    end
  end

  assign req0_ready = gnt_valid_s && !gnt_id_s;
  assign req1_ready = gnt_valid_s && gnt_id_s;

  // Operand mux feeding the shared datapath and response consume select
  always_comb begin
    sel_op_s   = req0_op;
    sel_a_s    = req0_a;
    sel_b_s    = req0_b;
    rsp_take_s = 1'b0;
    if (gnt_id_s) begin
      sel_op_s = req1_op;
      sel_a_s  = req1_a;
      sel_b_s  = req1_b;
    end else begin
      sel_op_s = req0_op;
      sel_a_s  = req0_a;
      sel_b_s  = req0_b;
    end
    if (gid_r) begin
      rsp_take_s = rsp1_ready;
    end else begin
      rsp_take_s = rsp0_ready;
    end
  end

  vec_alu_i8v4 #(.LAT(LAT)) u_alu (
    .clock (clock),
    .reset (reset),
    .load  (gnt_valid_s),
    .op    (sel_op_s),
    .a     (sel_a_s),
    .b     (sel_b_s),
    .y     (alu_y_s)
  );

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (gnt_valid_s) state_next_s = BUSY;
        else             state_next_s = IDLE;
      end
      BUSY: begin
        if (cnt_r == CNT_LAST) state_next_s = RESP;
        else                   state_next_s = BUSY;
      end
      RESP: begin
        if (rsp_take_s) state_next_s = IDLE;
        else            state_next_s = RESP;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, grant bookkeeping, latency counter and result hold register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      gid_r        <= 1'b0;
      prio_r       <= 1'b0;
      cnt_r        <= 4'd0;
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
      rsp_y_r      <= {VEC_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      case (state_r)
        IDLE: begin
          if (gnt_valid_s) begin
            gid_r  <= gnt_id_s;
            prio_r <= ~gnt_id_s;
            cnt_r  <= 4'd0;
          end
        end
        BUSY: begin
          if (cnt_r == CNT_LAST) begin
            rsp_y_r      <= alu_y_s;
            rsp0_valid_r <= ~gid_r;
            rsp1_valid_r <= gid_r;
            cnt_r        <= 4'd0;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        RESP: begin
          if (rsp_take_s) begin
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            rsp_y_r      <= {VEC_W{1'b0}};
          end
        end
        default: begin
          rsp0_valid_r <= 1'b0;
          rsp1_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign rsp0_valid = rsp0_valid_r;
  assign rsp1_valid = rsp1_valid_r;
  assign rsp_y      = rsp_y_r;

endmodule

// File: tb/tb_vec_alu_arbiter.sv
// Directed self-checking bench for vec_alu_arbiter (LAT = 2).
module tb_vec_alu_arbiter;

  localparam int LAT = 2;

  logic        clock;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic        req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp_y;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  vec_alu_arbiter #(.LAT(LAT)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_y      (rsp_y)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #3;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation from requester id, then wait for and consume its result.
  task automatic run_txn(input string tag, input logic id, input logic op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_y);
    int lat;
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    #1;
    check({tag, "_ready"}, 32'(id ? req1_ready : req0_ready), 32'd1);
    check({tag, "_other_ready"}, 32'(id ? req0_ready : req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 1;
    while (((id ? rsp1_valid : rsp0_valid) !== 1'b1) && (lat < 20)) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(LAT + 1));
    check({tag, "_y"}, rsp_y, exp_y);
    check({tag, "_other_rsp"}, 32'(id ? rsp0_valid : rsp1_valid), 32'd0);
    if (id) rsp1_ready = 1'b1;
    else    rsp0_ready = 1'b1;
    tick();
    check({tag, "_consumed"}, 32'(id ? rsp1_valid : rsp0_valid), 32'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  initial begin
    int g, cyc, last, seen;
    logic [31:0] exp_sub_sat, exp_add_sat;

`ifdef VEC_ALU_ARBITER_SAT_EN
    exp_sub_sat = 32'h0000_0080;
    exp_add_sat = 32'hfe30_807f;
`else
    exp_sub_sat = 32'h0000_007f;
    exp_add_sat = 32'hfe30_7f80;
`endif

    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 1'b0; req1_op = 1'b0;
    req0_a = 32'h0; req0_b = 32'h0; req1_a = 32'h0; req1_b = 32'h0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset values, with a request presented that must not be accepted
    tick(); tick();
    req0_valid = 1'b1;
    #1;
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst_rsp_y", rsp_y, 32'h0);
    tick();
    req0_valid = 1'b0;
    reset = 1'b0;
    tick();

    // Simultaneous requests: req0 first after reset, then strict alternation
    req0_op = 1'b0; req0_a = 32'h0102_0304; req0_b = 32'h1010_1010;
    req1_op = 1'b1; req1_a = 32'h0000_0000; req1_b = 32'h0101_0101;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    g = 0; cyc = 0; last = 0;
    #1;
    while ((g < 4) && (cyc < 40)) begin
      if (req0_ready || req1_ready) begin
        check($sformatf("alt_grant%0d", g), 32'(req1_ready), 32'(g % 2));
        check($sformatf("alt_both%0d", g), 32'(req0_ready && req1_ready), 32'd0);
        if (g > 0) check($sformatf("alt_gap%0d", g), 32'(cyc - last), 32'(LAT + 2));
        last = cyc;
        g++;
      end
      if (rsp0_valid) check("alt_y0", rsp_y, 32'h1112_1314);
      if (rsp1_valid) check("alt_y1", rsp_y, 32'hffff_ffff);
      tick(); #1;
      cyc++;
    end
    check("alt_count", 32'(g), 32'd4);
    req0_valid = 1'b0; req1_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      if (rsp1_valid) begin
        check("alt_last_y", rsp_y, 32'hffff_ffff);
        seen++;
      end
      tick();
    end
    check("alt_last_seen", 32'(seen), 32'd1);
    check("alt_drained", 32'(rsp0_valid | rsp1_valid), 32'd0);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Lane arithmetic: sub example, wrap/saturate corners, no inter-lane carry
    run_txn("sub_req0", 1'b0, 1'b1, 32'h0102_02fc, 32'h0100_0301, 32'h0002_fffb);
    run_txn("sub_min", 1'b1, 1'b1, 32'h0000_0080, 32'h0000_0001, exp_sub_sat);
    run_txn("add_corner", 1'b0, 1'b0, 32'hff10_807f, 32'hff20_ff01, exp_add_sat);

    // Response held for 5 cycles; non-granted rsp_ready and new requests ignored
    req1_op = 1'b0; req1_a = 32'h0a0b_0c0d; req1_b = 32'h0101_0101;
    req1_valid = 1'b1;
    #1;
    check("hold_accept", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    for (int i = 0; i < LAT; i++) tick();
    rsp0_ready = 1'b1;
    req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("hold_valid%0d", i), 32'(rsp1_valid), 32'd1);
      check($sformatf("hold_y%0d", i), rsp_y, 32'h0b0c_0d0e);
      check($sformatf("hold_noready%0d", i), 32'(req0_ready | req1_ready), 32'd0);
      check($sformatf("hold_rsp0%0d", i), 32'(rsp0_valid), 32'd0);
      tick();
    end
    req0_valid = 1'b0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b1;
    tick();
    check("hold_released", 32'(rsp1_valid), 32'd0);
    rsp1_ready = 1'b0;

    // Reset in BUSY discards the result and restores requester-0 priority
    req0_op = 1'b0; req0_a = 32'h0000_0001; req0_b = 32'h0000_0001;
    req0_valid = 1'b1;
    #1;
    check("rstbusy_accept", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstbusy_rsp_y", rsp_y, 32'h0);
    seen = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      if (rsp0_valid || rsp1_valid) seen++;
      tick();
    end
    check("rstbusy_no_rsp", 32'(seen), 32'd0);
    req1_op = 1'b0; req1_a = 32'h0; req1_b = 32'h0;
    req1_valid = 1'b1;
    run_txn("post_rst", 1'b0, 1'b0, 32'h0203_0405, 32'h0101_0101, 32'h0304_0506);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/vec_alu_arbiter.md
VEC_ALU_ARBITER -- requirements
Module: vec_alu_arbiter

Interface
REQ-001 Parameter: LAT, default 2, pipeline latency in cycles of the shared i8v4 ALU (legal 1..8).
REQ-002 Port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-005 Port: req0_ready / req1_ready  output  1  requester n operation accepted this cycle.
REQ-006 Port: req0_op / req1_op  input  1  0 = add, 1 = sub (y = a - b).
REQ-007 Port: req0_a / req1_a, req0_b / req1_b  input  32  packed 4-lane i8 operands; lane k = bits [8k+7:8k].
REQ-008 Port: rsp0_valid / rsp1_valid  output  1  result available for requester n.
REQ-009 Port: rsp0_ready / rsp1_ready  input  1  requester n consumes the result.
REQ-010 Port: rsp_y  output  32  packed 4-lane i8 result; valid only while some rsp*_valid is high.

Function
REQ-011 FSM states: IDLE, BUSY, RESP; the ALU is shared and holds at most one operation in flight.
REQ-012 IDLE: if any req*_valid, grant one, assert its req_ready for exactly that cycle, latch op/a/b and the grant ID, go to BUSY.
REQ-013 Arbitration: round-robin; on simultaneous requests, grant the requester not granted last; after reset, requester 0 has priority.
REQ-014 BUSY: count LAT cycles from the accept cycle, then go to RESP; no req_ready is asserted in BUSY or RESP.
REQ-015 RESP: assert rsp_valid only for the granted ID; hold rsp_y stable until the matching rsp_ready is high.
REQ-016 RESP with rsp_ready high: return to IDLE; a new grant occurs no earlier than the following cycle.
REQ-017 Accept-to-rsp_valid latency is LAT+1 cycles; minimum issue interval is LAT+2 cycles.
REQ-018 Lane arithmetic: independent per lane, two's-complement 8-bit; no carry or borrow between lanes.
REQ-019 rsp_ready for the non-granted ID is ignored; req_valid dropping while BUSY has no effect.

Reset
REQ-020 In reset: state IDLE, req*_ready = 0, rsp*_valid = 0, rsp_y = 0, round-robin pointer = requester 0, LAT counter = 0.
REQ-021 Reset asserted mid-operation discards the in-flight result; no rsp_valid is produced for it.

Configuration
REQ-022 With VEC_ALU_ARBITER_SAT_EN defined, each lane result SHALL saturate to [-128, 127].
REQ-023 Without VEC_ALU_ARBITER_SAT_EN, each lane result SHALL wrap modulo 256; ports and timing are identical in both builds.

Structure
REQ-024 Shared package vec_alu_pkg SHALL hold the lane width (8), lane count (4), the op encoding constants ADD/SUB and the FSM state enum.
REQ-025 One sub-module, vec_alu_i8v4, SHALL implement the LAT-stage lane datapath; the arbiter owns the FSM, counter and result hold register.

Verification
REQ-026 req0 sub a=[-4,2,2,1] b=[1,3,0,1] -> rsp0_valid after LAT+1 cycles, y=[-5,-1,2,0].
REQ-027 req0 and req1 both valid in the same cycle after reset -> req0 granted first, req1 granted after rsp0 is consumed.
REQ-028 Two back-to-back simultaneous requests, repeated -> grants alternate 0,1,0,1.
REQ-029 req1 sub a=[-128,0,0,0] b=[1,0,0,0] -> lane0 = 127 without the macro, -128 with VEC_ALU_ARBITER_SAT_EN; add [127]+[1] -> -128 or 127 respectively.
REQ-030 rsp_ready held low for 5 cycles in RESP -> rsp_valid and rsp_y stable throughout, no new req_ready.
REQ-031 Reset pulsed during BUSY -> no rsp_valid afterwards, outputs at reset values, next request accepted normally.
